// File: rtl/fabric_pe_operand_join_if.sv
// Bundle of the operand-join handshake signals. Producers drive in_* and the
// PE consumes out_*. The slave modport is the join block's view.
interface fabric_pe_operand_join_if #(
  parameter int NUM_INPUTS = 2,
  parameter int SAFE_PW    = 32
);
  // Handshake: a transfer happens on a rising edge where valid && ready.
  // valid never waits on ready; ready never depends on valid or out_ready.
  // Data is held stable while valid is high and ready is low.
  logic [NUM_INPUTS-1:0]              in_valid;
  logic [NUM_INPUTS-1:0]              in_ready;
  logic [NUM_INPUTS-1:0][SAFE_PW-1:0] in_data;
  logic                               out_valid;
  logic                               out_ready;
  logic [NUM_INPUTS-1:0][SAFE_PW-1:0] out_data;
  logic                               err_tag_mismatch;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, err_tag_mismatch
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, err_tag_mismatch
  );
endinterface

// File: rtl/fabric_pe_operand_join.sv
// Operand join ahead of fabric_pe: one elastic FIFO per operand stream; a bundle
// is released only when every head is present and, in tagged mode, all tags agree.
module fabric_pe_operand_join #(
  parameter int NUM_INPUTS = 2,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 0,
  parameter int DEPTH      = 2
) (
  input logic                     clk,
  input logic                     rst,
  fabric_pe_operand_join_if.slave bus
);
  localparam int PAYLOAD_WIDTH = DATA_WIDTH + TAG_WIDTH;
  localparam int SAFE_PW       = (PAYLOAD_WIDTH > 1) ? PAYLOAD_WIDTH : 1;
  localparam int PTR_W         = $clog2(DEPTH);
  localparam int CNT_W         = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [SAFE_PW-1:0]                 mem_q [NUM_INPUTS][DEPTH];
  logic [NUM_INPUTS-1:0][PTR_W-1:0]   wptr_q, wptr_d;
  logic [NUM_INPUTS-1:0][PTR_W-1:0]   rptr_q, rptr_d;
  logic [NUM_INPUTS-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic                               err_q, err_d;
  logic [NUM_INPUTS-1:0]              ready;
  logic [NUM_INPUTS-1:0]              push;
  logic [NUM_INPUTS-1:0][SAFE_PW-1:0] head;
  logic                               all_present;
  logic                               tags_eq;
  logic                               out_valid;
  logic                               fire;

  // Readiness is a function of occupancy only, so a full FIFO stalls its
  // writer even in a cycle where the join pops it.
  always_comb begin
    all_present = 1'b1;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      ready[i]    = !rst && (cnt_q[i] != FULL_CNT);
      push[i]     = bus.in_valid[i] && ready[i];
      head[i]     = mem_q[i][rptr_q[i]];
      all_present = all_present && (cnt_q[i] != '0);
    end
  end

  if (TAG_WIDTH > 0) begin : g_tagged
    always_comb begin
      tags_eq = 1'b1;
      for (int i = 1; i < NUM_INPUTS; i++) begin
        if (head[i][SAFE_PW-1 -: TAG_WIDTH] != head[0][SAFE_PW-1 -: TAG_WIDTH]) begin
          tags_eq = 1'b0;
        end
      end
    end
  end else begin : g_untagged
    assign tags_eq = 1'b1;
  end

  // all_present gates the tag compare so stale storage never reaches out_valid.
  assign out_valid = all_present && tags_eq;
  assign fire      = out_valid && bus.out_ready;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (push[i]) begin
        wptr_d[i] = wptr_q[i] + PTR_W'(1);
      end
      if (fire) begin
        rptr_d[i] = rptr_q[i] + PTR_W'(1);
      end
      if (push[i] && !fire) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (!push[i] && fire) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
    err_d = err_q || (all_present && !tags_eq);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  // Payload storage carries no reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (push[i]) begin
        mem_q[i][wptr_q[i]] <= bus.in_data[i];
      end
    end
  end

  assign bus.in_ready         = ready;
  assign bus.out_valid        = out_valid;
  assign bus.out_data         = head;
  assign bus.err_tag_mismatch = err_q;
endmodule

// File: tb/tb_fabric_pe_operand_join.sv
// Bench for fabric_pe_operand_join: an untagged DEPTH=2 instance and a tagged
// DEPTH=4 instance, with per-lane expected queues checked on every fire.
module tb_fabric_pe_operand_join;
  localparam int NI  = 2;
  localparam int PW0 = 32;
  localparam int PW1 = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fabric_pe_operand_join_if #(.NUM_INPUTS(NI), .SAFE_PW(PW0)) if0 ();
  fabric_pe_operand_join_if #(.NUM_INPUTS(NI), .SAFE_PW(PW1)) if1 ();

  fabric_pe_operand_join #(
    .NUM_INPUTS(NI), .DATA_WIDTH(32), .TAG_WIDTH(0), .DEPTH(2)
  ) u_dut0 (
    .clk(clk), .rst(rst), .bus(if0.slave)
  );

  fabric_pe_operand_join #(
    .NUM_INPUTS(NI), .DATA_WIDTH(8), .TAG_WIDTH(4), .DEPTH(4)
  ) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave)
  );

  int n_cmp  = 0;
  int n_err  = 0;
  int fires0 = 0;
  int fires1 = 0;

  logic [PW0-1:0] exp0_a_q[$];
  logic [PW0-1:0] exp0_b_q[$];
  logic [PW1-1:0] exp1_a_q[$];
  logic [PW1-1:0] exp1_b_q[$];

  logic [PW0-1:0] src0 [NI][32];
  logic [PW1-1:0] src1 [NI][32];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: record accepted pushes, compare heads when a bundle fires.
  always @(negedge clk) begin
    if (rst) begin
      exp0_a_q.delete();
      exp0_b_q.delete();
    end else begin
      if (if0.out_valid && if0.out_ready) begin
        fires0++;
        check("sb0_avail", 64'(exp0_a_q.size() != 0 && exp0_b_q.size() != 0), 64'd1);
        if (exp0_a_q.size() != 0) check("sb0_lane0", 64'(if0.out_data[0]), 64'(exp0_a_q.pop_front()));
        if (exp0_b_q.size() != 0) check("sb0_lane1", 64'(if0.out_data[1]), 64'(exp0_b_q.pop_front()));
      end
      if (if0.in_valid[0] && if0.in_ready[0]) exp0_a_q.push_back(if0.in_data[0]);
      if (if0.in_valid[1] && if0.in_ready[1]) exp0_b_q.push_back(if0.in_data[1]);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      exp1_a_q.delete();
      exp1_b_q.delete();
    end else begin
      if (if1.out_valid && if1.out_ready) begin
        fires1++;
        check("sb1_avail", 64'(exp1_a_q.size() != 0 && exp1_b_q.size() != 0), 64'd1);
        if (exp1_a_q.size() != 0) check("sb1_lane0", 64'(if1.out_data[0]), 64'(exp1_a_q.pop_front()));
        if (exp1_b_q.size() != 0) check("sb1_lane1", 64'(if1.out_data[1]), 64'(exp1_b_q.pop_front()));
      end
      if (if1.in_valid[0] && if1.in_ready[0]) exp1_a_q.push_back(if1.in_data[0]);
      if (if1.in_valid[1] && if1.in_ready[1]) exp1_b_q.push_back(if1.in_data[1]);
    end
  end

  task automatic run0(input int n_a, input int n_b, input int gap_pct, input int rdy_pct,
                      input int budget, output int cyc);
    int ia = 0;
    int ib = 0;
    logic [NI-1:0] acc;
    cyc = 0;
    while ((ia < n_a || ib < n_b || if0.out_valid) && cyc < budget) begin
      if0.in_valid[0] = (ia < n_a) && ($urandom_range(99) >= gap_pct);
      if0.in_valid[1] = (ib < n_b) && ($urandom_range(99) >= gap_pct);
      if0.in_data[0]  = src0[0][ia];
      if0.in_data[1]  = src0[1][ib];
      if0.out_ready   = ($urandom_range(99) < rdy_pct);
      #1;
      acc = if0.in_valid & if0.in_ready;
      tick();
      if (acc[0]) ia++;
      if (acc[1]) ib++;
      cyc++;
    end
    if0.in_valid  = '0;
    if0.out_ready = 1'b0;
    check("run0_budget", 64'(cyc < budget), 64'd1);
  endtask

  task automatic run1(input int n_a, input int n_b, input int gap_pct, input int rdy_pct,
                      input int budget, output int cyc);
    int ia = 0;
    int ib = 0;
    logic [NI-1:0] acc;
    cyc = 0;
    while ((ia < n_a || ib < n_b || if1.out_valid) && cyc < budget) begin
      if1.in_valid[0] = (ia < n_a) && ($urandom_range(99) >= gap_pct);
      if1.in_valid[1] = (ib < n_b) && ($urandom_range(99) >= gap_pct);
      if1.in_data[0]  = src1[0][ia];
      if1.in_data[1]  = src1[1][ib];
      if1.out_ready   = ($urandom_range(99) < rdy_pct);
      #1;
      acc = if1.in_valid & if1.in_ready;
      tick();
      if (acc[0]) ia++;
      if (acc[1]) ib++;
      cyc++;
    end
    if1.in_valid  = '0;
    if1.out_ready = 1'b0;
    check("run1_budget", 64'(cyc < budget), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, n_cmp %0d", n_cmp);
    $fatal(1);
  end

  initial begin
    int cyc;
    int f0;
    int f1;
    rst           = 1'b1;
    if0.in_valid  = '0;
    if0.in_data   = '0;
    if0.out_ready = 1'b0;
    if1.in_valid  = '0;
    if1.in_data   = '0;
    if1.out_ready = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_in_ready0", 64'(if0.in_ready), 64'd0);
    check("rst_in_ready1", 64'(if1.in_ready), 64'd0);
    check("rst_out_valid0", 64'(if0.out_valid), 64'd0);
    check("rst_err1", 64'(if1.err_tag_mismatch), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready0", 64'(if0.in_ready), 64'h3);
    check("post_rst_valid0", 64'(if0.out_valid), 64'd0);

    // Basic join: in0 alone stalls, in1 arrival releases the bundle next edge
    if0.in_valid   = 2'b01;
    if0.in_data[0] = 32'h11;
    tick();
    if0.in_valid   = 2'b10;
    if0.in_data[1] = 32'h22;
    check("t1_wait_in1", 64'(if0.out_valid), 64'd0);
    tick();
    if0.in_valid = '0;
    check("t1_valid", 64'(if0.out_valid), 64'd1);
    check("t1_data", 64'(if0.out_data), {32'h22, 32'h11});
    if0.out_ready = 1'b1;
    tick();
    if0.out_ready = 1'b0;
    check("t1_drained", 64'(if0.out_valid), 64'd0);
    check("t1_cnt", 64'(u_dut0.cnt_q), 64'd0);

    // Backpressure: third push on in0 held while the FIFO is full
    f0 = fires0;
    if0.in_valid   = 2'b01;
    if0.in_data[0] = 32'hA0;
    tick();
    if0.in_data[0] = 32'hA1;
    check("t2_ready_1", 64'(if0.in_ready[0]), 64'd1);
    tick();
    if0.in_data[0] = 32'hA2;
    check("t2_full", 64'(if0.in_ready[0]), 64'd0);
    tick();
    check("t2_held", 64'(if0.in_ready[0]), 64'd0);
    check("t2_no_out", 64'(if0.out_valid), 64'd0);
    src0[0][0] = 32'hA2;
    src0[1][0] = 32'hB0;
    src0[1][1] = 32'hB1;
    src0[1][2] = 32'hB2;
    run0(1, 3, 0, 100, 100, cyc);
    check("t2_fires", 64'(fires0 - f0), 64'd3);
    check("t2_empty", 64'(exp0_a_q.size() + exp0_b_q.size()), 64'd0);

    // Streaming: one bundle per cycle after a single fill cycle
    for (int k = 0; k < 16; k++) begin
      src0[0][k] = 32'h1000 + 32'(k);
      src0[1][k] = 32'h2000 + 32'(k);
    end
    f0 = fires0;
    run0(16, 16, 0, 100, 100, cyc);
    check("t3_fires", 64'(fires0 - f0), 64'd16);
    check("t3_cycles", 64'(cyc), 64'd17);

    // Pointer wrap on the tagged DEPTH=4 instance with random gaps and ready
    for (int k = 0; k < 10; k++) begin
      src1[0][k] = {4'(k), 8'($urandom_range(255))};
      src1[1][k] = {4'(k), 8'($urandom_range(255))};
    end
    f1 = fires1;
    run1(10, 10, 30, 50, 1000, cyc);
    check("t6_fires", 64'(fires1 - f1), 64'd10);
    check("t6_empty", 64'(exp1_a_q.size() + exp1_b_q.size()), 64'd0);
    check("t6_no_err", 64'(if1.err_tag_mismatch), 64'd0);

    // Tagged: matching tags fire intact, differing tags stall and stick the error
    if1.in_valid   = 2'b11;
    if1.in_data[0] = {4'h3, 8'h5A};
    if1.in_data[1] = {4'h3, 8'hC3};
    tick();
    if1.in_valid = '0;
    check("t4_match_valid", 64'(if1.out_valid), 64'd1);
    check("t4_match_data", 64'(if1.out_data), {12'h3C3, 12'h35A});
    if1.out_ready = 1'b1;
    tick();
    if1.out_ready = 1'b0;
    check("t4_match_popped", 64'(if1.out_valid), 64'd0);
    if1.in_valid   = 2'b11;
    if1.in_data[0] = {4'h5, 8'h01};
    if1.in_data[1] = {4'h6, 8'h02};
    tick();
    if1.in_valid = '0;
    check("t4_mis_valid", 64'(if1.out_valid), 64'd0);
    check("t4_err_not_yet", 64'(if1.err_tag_mismatch), 64'd0);
    tick();
    check("t4_err_set", 64'(if1.err_tag_mismatch), 64'd1);
    if1.out_ready = 1'b1;
    repeat (3) tick();
    if1.out_ready = 1'b0;
    check("t4_err_sticky", 64'(if1.err_tag_mismatch), 64'd1);
    check("t4_stalled", 64'(if1.out_valid), 64'd0);
    check("t4_no_drop", 64'(u_dut1.cnt_q), {3'd1, 3'd1});

    // Reset mid-operation discards buffered entries and clears the error
    if0.in_valid   = 2'b11;
    if0.in_data[0] = 32'hC0;
    if0.in_data[1] = 32'hC1;
    tick();
    if0.in_valid = '0;
    check("t5_buffered", 64'(if0.out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("t5_rst_ready0", 64'(if0.in_ready), 64'd0);
    check("t5_rst_ready1", 64'(if1.in_ready), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("t5_ready0", 64'(if0.in_ready), 64'h3);
    check("t5_valid0", 64'(if0.out_valid), 64'd0);
    check("t5_valid1", 64'(if1.out_valid), 64'd0);
    check("t5_err1", 64'(if1.err_tag_mismatch), 64'd0);
    check("t5_cnt0", 64'(u_dut0.cnt_q), 64'd0);
    check("t5_cnt1", 64'(u_dut1.cnt_q), 64'd0);
    for (int k = 0; k < 3; k++) begin
      src0[0][k] = 32'hD0 + 32'(k);
      src0[1][k] = 32'hE0 + 32'(k);
    end
    f0 = fires0;
    run0(3, 3, 0, 100, 50, cyc);
    check("t5_fires", 64'(fires0 - f0), 64'd3);
    check("t5_empty", 64'(exp0_a_q.size() + exp0_b_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fabric_pe_operand_join.md
Name: fabric_pe_operand_join

Overview:
- Input stage placed directly upstream of fabric_pe.
- Each of NUM_INPUTS operand streams gets its own small elastic FIFO.
- A single joined operand bundle is presented to the PE only when every input has a head entry and, in tagged mode, all head tags agree.
- Decouples independent producer handshakes from the PE's all-operands-present firing rule.

Parameters:
NUM_INPUTS, 2, number of operand streams joined (>=1)
DATA_WIDTH, 32, payload data bits per operand
TAG_WIDTH, 0, tag bits per operand; 0 = untagged mode
DEPTH, 2, entries per input FIFO; power of two, >=2

Derived widths:
- PAYLOAD_WIDTH = DATA_WIDTH+TAG_WIDTH.
- SAFE_PW = max(PAYLOAD_WIDTH,1).
- Tag occupies the upper TAG_WIDTH bits of each payload.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  NUM_INPUTS  per-input producer valid
in_ready  output  NUM_INPUTS  per-input FIFO can accept
in_data  input  [NUM_INPUTS][SAFE_PW]  per-input payload (tag in MSBs)
out_valid  output  1  joined bundle available to PE
out_ready  input  1  PE accepts bundle
out_data  output  [NUM_INPUTS][SAFE_PW]  head payload of each FIFO, tags preserved
err_tag_mismatch  output  1  sticky: all heads present but tags differ

Behaviour:
Reset (rst high at a clock edge):
- All FIFO read/write pointers and counts cleared.
- err_tag_mismatch = 0.
- in_ready = 0 for every cycle rst is high.
- out_valid = 0.
- out_data content is don't-care but must not be X-propagated into out_valid.
- Reset mid-operation discards all buffered entries.
- First cycle after rst deasserts: in_ready = all 1, out_valid = 0.

Per-input FIFO i:
- Registered storage of DEPTH x SAFE_PW.
- count width clog2(DEPTH+1).
- in_ready[i] = !rst && (count[i] != DEPTH). No combinational dependence on out_ready; full-with-pop still stalls the writer that cycle.
- push[i] = in_valid[i] && in_ready[i]; writes at wptr, wptr wraps modulo DEPTH.
- Push and pop in the same cycle: count unchanged, both pointers advance.

Join:
- all_present = AND over i of (count[i] != 0).
- tags_eq: 1 when TAG_WIDTH==0, else all head tags equal the head tag of input 0.
- out_valid = all_present && tags_eq. Combinational from registers only; never depends on out_ready.
- fire = out_valid && out_ready; pops every FIFO simultaneously. No partial pops ever.
- out_data[i] = storage[i][rptr[i]], held stable while out_valid && !out_ready.
- Minimum latency: a payload accepted on edge N is visible on out_data/out_valid after edge N (1 cycle), given all other inputs are present.

Throughput:
- DEPTH>=2 sustains one bundle per cycle with continuous valid and out_ready = 1.

Tag mismatch:
- When all_present && !tags_eq, err_tag_mismatch sets on the next edge and stays set until rst.
- out_valid stays 0, so the join stalls; no entries are dropped.

Misc:
- NUM_INPUTS==1: degenerates to a plain FIFO; tags_eq is always 1.
- No X on in_data may propagate to out_valid.

Test Plan:
1. Reset, then DATA_WIDTH=32, NI=2, TW=0: push 0x11 on in0 only -> out_valid stays 0. Push 0x22 on in1 next cycle -> out_valid=1 one cycle later, out_data={0x22,0x11}. out_ready=1 pops both; counts return to 0.
2. Backpressure: out_ready=0, push 3 entries on in0 with DEPTH=2 -> in_ready[0] drops after the 2nd accept and the 3rd is held. Raise out_ready and feed in1 -> bundles emerge in FIFO order 1st, 2nd, 3rd with no loss or duplication.
3. Streaming: both inputs valid every cycle, out_ready=1, DEPTH=2, 16 sequential values -> 16 bundles over 16 consecutive cycles after a 1-cycle fill, values matched pairwise.
4. Tagged mode TW=4: in0 tag 3, in1 tag 3 -> bundle fires with tags intact. Next in0 tag 5, in1 tag 6 -> out_valid=0, err_tag_mismatch=1 next cycle and remains 1.
5. Reset mid-operation: one entry buffered in each FIFO, pulse rst for 1 cycle -> in_ready=0 during reset; afterwards out_valid=0, err=0, counts=0, and the old data never appears.
6. Pointer wrap: DEPTH=4, 10 bundles with randomized in_valid gaps and out_ready toggling -> output order matches a per-input scoreboard across multiple pointer wraps.
